// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus timer: register offsets, CTRL field layout,
// MTIMECMP reset value and a byte-lane write-merge helper.
// No ports; imported by bus_timer and bus_timer_prescaler.
package bus_timer_pkg;

    // Word offsets decoded from dev_addr_i[4:2]; 5-7 are unmapped.
    typedef enum logic [2:0] {
        REG_CTRL        = 3'd0,
        REG_MTIME_LO    = 3'd1,
        REG_MTIME_HI    = 3'd2,
        REG_MTIMECMP_LO = 3'd3,
        REG_MTIMECMP_HI = 3'd4
    } reg_off_e;

    // CTRL field positions.
    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;

    // Compare value out of reset is the maximum so the interrupt stays quiet.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler: counts enabled cycles and emits a tick when the count equals prescale_i.
// Latency: tick_o is combinational from the registered count; counter updates on clk_i.
// No backpressure. Ports: clk_i, rst_ni, enable_i, prescale_i, clear_i (CTRL write), tick_o.
module bus_timer_prescaler
    import bus_timer_pkg::*;
#(
    parameter int unsigned PrescaleWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [PrescaleWidth-1:0] prescale_i,
    input  logic                     clear_i,
    output logic                     tick_o
);

    logic [PrescaleWidth-1:0] cnt_q, cnt_d;
    logic                     at_limit;

    assign at_limit = (cnt_q == prescale_i);

    // A CTRL write restarts the period and suppresses any tick in that cycle.
    assign tick_o = enable_i && !clear_i && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = at_limit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt (CTRL, MTIME, MTIMECMP).
// Latency: every request answered exactly one cycle later; irq registered one cycle behind state.
// No backpressure: requests always accepted. Ports: clk_i, rst_ni, dev_* bus, timer_irq_o.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,  // only 32 is supported
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned PrescaleWidth = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dev_req_i,
    input  logic [AddressWidth-1:0]   dev_addr_i,
    input  logic                      dev_we_i,
    input  logic [DataWidth/8-1:0]    dev_be_i,
    input  logic [DataWidth-1:0]      dev_wdata_i,
    output logic                      dev_rvalid_o,
    output logic [DataWidth-1:0]      dev_rdata_o,
    output logic                      dev_err_o,
    output logic                      timer_irq_o
);

    logic                     ctrl_en_q, ctrl_en_d;
    logic [PrescaleWidth-1:0] ctrl_presc_q, ctrl_presc_d;
    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic                     rvalid_q, err_q, irq_q;
    logic [DataWidth-1:0]     rdata_q, rdata_d;

    logic [2:0]               off;
    logic                     mapped;
    logic                     wr_en;
    logic                     ctrl_wr;
    logic                     tick;
    logic [DataWidth-1:0]     ctrl_word;
    logic [DataWidth-1:0]     reg_rdata;
    logic [DataWidth-1:0]     wr_merged;

    // Only the word offset is decoded; remaining address bits are ignored.
    logic unused_addr;
    assign unused_addr = ^{dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};

    assign off     = dev_addr_i[4:2];
    assign mapped  = (off <= REG_MTIMECMP_HI);
    assign wr_en   = dev_req_i && dev_we_i && mapped;
    assign ctrl_wr = wr_en && (off == REG_CTRL);

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN_BIT] = ctrl_en_q;
        ctrl_word[CTRL_PRESCALE_LSB +: PrescaleWidth] = ctrl_presc_q;
    end

    // Current register value at the addressed offset; doubles as the
    // "old value" for byte-lane merging on writes.
    always_comb begin
        reg_rdata = '0;
        case (off)
            REG_CTRL:        reg_rdata = ctrl_word;
            REG_MTIME_LO:    reg_rdata = mtime_q[31:0];
            REG_MTIME_HI:    reg_rdata = mtime_q[63:32];
            REG_MTIMECMP_LO: reg_rdata = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: reg_rdata = mtimecmp_q[63:32];
            default:         reg_rdata = '0;
        endcase
    end

    assign wr_merged = merge_be(reg_rdata, dev_wdata_i, dev_be_i);

    bus_timer_prescaler #(
        .PrescaleWidth (PrescaleWidth)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .enable_i   (ctrl_en_q),
        .prescale_i (ctrl_presc_q),
        .clear_i    (ctrl_wr),
        .tick_o     (tick)
    );

    // A bus write to either MTIME half overrides the tick increment entirely.
    always_comb begin
        ctrl_en_d    = ctrl_en_q;
        ctrl_presc_d = ctrl_presc_q;
        mtime_d      = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d   = mtimecmp_q;
        if (wr_en) begin
            case (off)
                REG_CTRL: begin
                    ctrl_en_d    = wr_merged[CTRL_EN_BIT];
                    ctrl_presc_d = wr_merged[CTRL_PRESCALE_LSB +: PrescaleWidth];
                end
                REG_MTIME_LO:    mtime_d    = {mtime_q[63:32], wr_merged};
                REG_MTIME_HI:    mtime_d    = {wr_merged, mtime_q[31:0]};
                REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wr_merged};
                REG_MTIMECMP_HI: mtimecmp_d = {wr_merged, mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    assign rdata_d = (dev_req_i && !dev_we_i && mapped) ? reg_rdata : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en_q    <= 1'b0;
            ctrl_presc_q <= '0;
            mtime_q      <= '0;
            mtimecmp_q   <= MTIMECMP_RST;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_en_q    <= ctrl_en_d;
            ctrl_presc_q <= ctrl_presc_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            rvalid_q     <= dev_req_i;
            err_q        <= dev_req_i && !mapped;
            rdata_q      <= rdata_d;
            irq_q        <= (mtime_q >= mtimecmp_q);
        end
    end

    assign dev_rvalid_o = rvalid_q;
    assign dev_err_o    = err_q;
    assign dev_rdata_o  = rdata_q;
    assign timer_irq_o  = irq_q;

endmodule
